// File: rtl/collision_detect.sv
// rtl/collision_detect.sv - frame-synchronous pong collision detector with per-paddle hit lockout
// Optional: COLLISION_HIT_ZONE_EN adds the registered hit_zone output.
module collision_detect #(
    parameter int X_W           = 10,
    parameter int Y_W           = 9,
    parameter int PADDLE_HEIGHT = 70,
    parameter int PADDLE_WIDTH  = 15,
    parameter int BALL_LEN      = 15,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int COOLDOWN      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic [X_W-1:0]     ball_x_min,
    input  logic [Y_W-1:0]     ball_y_min,
    input  logic               ball_dir_x,
    input  logic [Y_W-1:0]     paddle1_y_min,
    input  logic [Y_W-1:0]     paddle2_y_min,
    output logic               paddle1_hit,
    output logic               paddle2_hit,
    output logic               wall_top,
    output logic               wall_bottom,
    output logic               score1,
    output logic               score2,
`ifdef COLLISION_HIT_ZONE_EN
    output logic [2:0]         hit_zone,
`endif
    output logic signed [Y_W:0] hit_intersect
);

    localparam int XW1 = X_W + 1;
    localparam int YW1 = Y_W + 1;
    localparam int CW  = $clog2(COOLDOWN + 1);

    localparam logic [YW1-1:0] L_BALL_HALF   = YW1'(BALL_LEN / 2);
    localparam logic [YW1-1:0] L_PAD_HALF    = YW1'(PADDLE_HEIGHT / 2);
    localparam logic [YW1-1:0] L_PAD_H       = YW1'(PADDLE_HEIGHT);
    localparam logic [YW1-1:0] L_BALL_LEN_Y  = YW1'(BALL_LEN);
    localparam logic [YW1-1:0] L_SCREEN_H    = YW1'(SCREEN_HEIGHT);
    localparam logic [XW1-1:0] L_BALL_LEN_X  = XW1'(BALL_LEN);
    localparam logic [XW1-1:0] L_SCREEN_W    = XW1'(SCREEN_WIDTH);
    localparam logic [XW1-1:0] L_RIGHT_FACE  = XW1'(SCREEN_WIDTH - PADDLE_WIDTH);
    localparam logic [X_W-1:0] L_LEFT_FACE   = X_W'(PADDLE_WIDTH);
    localparam logic [CW-1:0]  L_COOLDOWN    = CW'(COOLDOWN);

    typedef enum logic {ST_ARMED, ST_LOCKED} state_t;

    logic [YW1-1:0] w_ball_mid, w_p1_top, w_p2_top, w_p1_mid, w_p2_mid;
    logic [XW1-1:0] w_ball_x_max;
    logic           w_contact1_raw, w_contact2_raw;
    logic [1:0]     w_contact, w_hit;
    logic           w_goal1, w_goal2, w_top, w_bot;

    state_t         r_state   [2];
    state_t         w_state_nx[2];
    logic [CW-1:0]  r_cnt     [2];
    logic [CW-1:0]  w_cnt_nx  [2];

    logic r_p1_hit, r_p2_hit, r_wall_top, r_wall_bot, r_score1, r_score2;
    logic r_goal1_prev, r_goal2_prev, r_top_prev, r_bot_prev;
    logic signed [Y_W:0] r_intersect;

    assign w_ball_mid   = {1'b0, ball_y_min} + L_BALL_HALF;
    assign w_p1_top     = {1'b0, paddle1_y_min};
    assign w_p2_top     = {1'b0, paddle2_y_min};
    assign w_p1_mid     = w_p1_top + L_PAD_HALF;
    assign w_p2_mid     = w_p2_top + L_PAD_HALF;
    assign w_ball_x_max = {1'b0, ball_x_min} + L_BALL_LEN_X;

    assign w_contact1_raw = (ball_x_min <= L_LEFT_FACE) && !ball_dir_x &&
                            (w_p1_top <= w_ball_mid) && (w_ball_mid <= w_p1_top + L_PAD_H);
    assign w_contact2_raw = (w_ball_x_max >= L_RIGHT_FACE) && ball_dir_x &&
                            (w_p2_top <= w_ball_mid) && (w_ball_mid <= w_p2_top + L_PAD_H);
    // Paddle 1 takes precedence if odd geometry ever makes both contacts true.
    assign w_contact = {w_contact2_raw && !w_contact1_raw, w_contact1_raw};

    assign w_goal2 = (ball_x_min == '0) && !w_contact1_raw;
    assign w_goal1 = (w_ball_x_max >= L_SCREEN_W) && !w_contact2_raw;
    assign w_top   = (ball_y_min == '0);
    assign w_bot   = ({1'b0, ball_y_min} + L_BALL_LEN_Y) >= L_SCREEN_H;

    // Contact while locked restarts the cooldown, so a lingering ball never re-triggers.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            w_hit[i]      = 1'b0;
            if (frame_tick) begin
                case (r_state[i])
                    ST_ARMED: begin
                        if (w_contact[i]) begin
                            w_hit[i]      = 1'b1;
                            w_state_nx[i] = ST_LOCKED;
                            w_cnt_nx[i]   = L_COOLDOWN;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_contact[i])
                            w_cnt_nx[i] = L_COOLDOWN;
                        else if (r_cnt[i] == '0)
                            w_state_nx[i] = ST_ARMED;
                        else
                            w_cnt_nx[i] = r_cnt[i] - 1'b1;
                    end
                    default: w_state_nx[i] = ST_ARMED;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= ST_ARMED;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
            end
        end
    end

`ifdef COLLISION_HIT_ZONE_EN
    logic [YW1+2:0] w_zone1_full, w_zone2_full;
    logic [2:0]     r_zone;
    assign w_zone1_full = {w_ball_mid - w_p1_top, 3'b000} / (YW1+3)'(PADDLE_HEIGHT + 1);
    assign w_zone2_full = {w_ball_mid - w_p2_top, 3'b000} / (YW1+3)'(PADDLE_HEIGHT + 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_zone <= '0;
        else if (w_hit[0])
            r_zone <= w_zone1_full[2:0];
        else if (w_hit[1])
            r_zone <= w_zone2_full[2:0];
    end
    assign hit_zone = r_zone;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_hit     <= 1'b0;
            r_p2_hit     <= 1'b0;
            r_wall_top   <= 1'b0;
            r_wall_bot   <= 1'b0;
            r_score1     <= 1'b0;
            r_score2     <= 1'b0;
            r_goal1_prev <= 1'b0;
            r_goal2_prev <= 1'b0;
            r_top_prev   <= 1'b0;
            r_bot_prev   <= 1'b0;
            r_intersect  <= '0;
        end else begin
            r_p1_hit   <= w_hit[0];
            r_p2_hit   <= w_hit[1];
            r_wall_top <= frame_tick && w_top && !r_top_prev;
            r_wall_bot <= frame_tick && w_bot && !r_bot_prev;
            r_score1   <= frame_tick && w_goal1 && !r_goal1_prev;
            r_score2   <= frame_tick && w_goal2 && !r_goal2_prev;
            if (frame_tick) begin
                r_goal1_prev <= w_goal1;
                r_goal2_prev <= w_goal2;
                r_top_prev   <= w_top;
                r_bot_prev   <= w_bot;
            end
            if (w_hit[0])
                r_intersect <= $signed(w_p1_mid - w_ball_mid);
            else if (w_hit[1])
                r_intersect <= $signed(w_p2_mid - w_ball_mid);
        end
    end

    assign paddle1_hit   = r_p1_hit;
    assign paddle2_hit   = r_p2_hit;
    assign wall_top      = r_wall_top;
    assign wall_bottom   = r_wall_bot;
    assign score1        = r_score1;
    assign score2        = r_score2;
    assign hit_intersect = r_intersect;

endmodule

// File: tb/tb_collision_detect.sv
// tb/tb_collision_detect.sv - scoreboard bench for collision_detect
module tb_collision_detect;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              frame_tick;
    logic [9:0]        ball_x_min;
    logic [8:0]        ball_y_min;
    logic              ball_dir_x;
    logic [8:0]        paddle1_y_min;
    logic [8:0]        paddle2_y_min;
    logic              paddle1_hit, paddle2_hit, wall_top, wall_bottom, score1, score2;
    logic signed [9:0] hit_intersect;
`ifdef COLLISION_HIT_ZONE_EN
    logic [2:0]        hit_zone;
`endif

    collision_detect dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_tick    (frame_tick),
        .ball_x_min    (ball_x_min),
        .ball_y_min    (ball_y_min),
        .ball_dir_x    (ball_dir_x),
        .paddle1_y_min (paddle1_y_min),
        .paddle2_y_min (paddle2_y_min),
        .paddle1_hit   (paddle1_hit),
        .paddle2_hit   (paddle2_hit),
        .wall_top      (wall_top),
        .wall_bottom   (wall_bottom),
        .score1        (score1),
        .score2        (score2),
`ifdef COLLISION_HIT_ZONE_EN
        .hit_zone      (hit_zone),
`endif
        .hit_intersect (hit_intersect)
    );

    always #5 clk = ~clk;

    // pulse vector order: {paddle1, paddle2, wall_top, wall_bottom, score1, score2}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] P1   = 6'b100000;
    localparam logic [5:0] P2   = 6'b010000;
    localparam logic [5:0] WT   = 6'b001000;
    localparam logic [5:0] WB   = 6'b000100;
    localparam logic [5:0] S1   = 6'b000010;
    localparam logic [5:0] S2   = 6'b000001;

    typedef struct {
        logic [5:0] pulses;
        int         hi;
        int         zone;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic tick_d;

    function automatic logic [5:0] act_pulses();
        return {paddle1_hit, paddle2_hit, wall_top, wall_bottom, score1, score2};
    endfunction

    always @(posedge clk or negedge reset_n)
        if (!reset_n) tick_d <= 1'b0;
        else          tick_d <= frame_tick;

    always @(negedge clk) begin
        if (reset_n) begin
            if (tick_d) begin
                exp_t e;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: response with no expectation, pulses=%b", act_pulses());
                end else begin
                    e = q.pop_front();
                    if (act_pulses() !== e.pulses) begin
                        errors++;
                        $display("FAIL %s pulses: got %b expected %b", e.name, act_pulses(), e.pulses);
                    end
                    checks++;
                    if (int'(hit_intersect) !== e.hi) begin
                        errors++;
                        $display("FAIL %s hit_intersect: got %0d expected %0d", e.name, hit_intersect, e.hi);
                    end
`ifdef COLLISION_HIT_ZONE_EN
                    checks++;
                    if (int'(hit_zone) !== e.zone) begin
                        errors++;
                        $display("FAIL %s hit_zone: got %0d expected %0d", e.name, hit_zone, e.zone);
                    end
`endif
                end
            end else begin
                checks++;
                if (act_pulses() !== NONE) begin
                    errors++;
                    $display("FAIL idle_pulses: got %b expected %b", act_pulses(), NONE);
                end
            end
        end
    end

    task automatic tick(input string name, input int bx, input int by, input logic dir,
                        input int p1, input int p2, input logic [5:0] ep, input int ehi, input int ez);
        exp_t e;
        @(negedge clk);
        ball_x_min    = 10'(bx);
        ball_y_min    = 9'(by);
        ball_dir_x    = dir;
        paddle1_y_min = 9'(p1);
        paddle2_y_min = 9'(p2);
        e.pulses = ep;
        e.hi     = ehi;
        e.zone   = ez;
        e.name   = name;
        q.push_back(e);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if ({act_pulses(), hit_intersect} !== 16'h0) begin
            errors++;
            $display("FAIL %s: pulses=%b hit_intersect=%0d expected all 0", name, act_pulses(), hit_intersect);
        end
`ifdef COLLISION_HIT_ZONE_EN
        checks++;
        if (hit_zone !== 3'd0) begin
            errors++;
            $display("FAIL %s hit_zone: got %0d expected 0", name, hit_zone);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        frame_tick    = 1'b0;
        ball_x_min    = 10'd300;
        ball_y_min    = 9'd200;
        ball_dir_x    = 1'b0;
        paddle1_y_min = 9'd300;
        paddle2_y_min = 9'd300;
        repeat (3) @(negedge clk);
        check_reset_state("reset_initial");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // left paddle hit, then held contact gives a single pulse
        tick("p1_first_hit", 15, 200, 0, 190, 300, P1, 18, 1);
        for (int i = 0; i < 5; i++)
            tick("p1_held", 15, 200, 0, 190, 300, NONE, 18, 1);
        tick("p1_clear_a", 100, 200, 0, 190, 300, NONE, 18, 1);
        tick("p1_recontact_early", 15, 200, 0, 190, 300, NONE, 18, 1);
        for (int i = 0; i < 5; i++)
            tick("p1_clear_b", 100, 200, 0, 190, 300, NONE, 18, 1);
        tick("p1_recontact_armed", 15, 200, 0, 190, 300, P1, 18, 1);

        // no tick: geometry in contact but everything frozen
        repeat (4) @(negedge clk);

        // reset while locked
        reset_n = 1'b0;
        #1;
        check_reset_state("reset_while_locked");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tick("p1_after_reset", 15, 200, 0, 190, 300, P1, 18, 1);

        // right paddle hit; wrong direction is a goal instead
        tick("p2_hit", 625, 200, 1, 300, 185, P2, 13, 2);
        tick("p2_wrong_dir", 625, 200, 0, 300, 185, S1, 13, 2);

        // goals, rising edge only
        tick("score2_first", 0, 300, 0, 50, 300, S2, 13, 2);
        tick("score2_held", 0, 300, 0, 50, 300, NONE, 13, 2);
        tick("score2_held", 0, 300, 0, 50, 300, NONE, 13, 2);
        tick("score1_first", 625, 300, 1, 300, 50, S1, 13, 2);
        tick("score1_held", 625, 300, 1, 300, 50, NONE, 13, 2);
        tick("score1_held", 625, 300, 1, 300, 50, NONE, 13, 2);

        // walls, rising edge only
        tick("wall_top", 300, 0, 0, 300, 300, WT, 13, 2);
        tick("wall_top_held", 300, 0, 0, 300, 300, NONE, 13, 2);
        tick("wall_bottom", 300, 465, 0, 300, 300, WB, 13, 2);
        tick("wall_bottom_held", 300, 465, 0, 300, 300, NONE, 13, 2);

        // corner: paddle and wall together
        tick("corner_hit", 15, 0, 0, 0, 300, P1 | WT, 28, 0);

        // lower edge of paddle window after cooldown
        for (int i = 0; i < 5; i++)
            tick("cooldown_clear", 300, 200, 0, 190, 300, NONE, 28, 0);
        tick("p1_bottom_edge", 15, 253, 0, 190, 300, P1, -35, 7);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
